// File: rtl/wgt_bank_reader_pkg.sv
// rtl/wgt_bank_reader_pkg.sv - shared constants, lane vector type and word-count helper
package wgt_bank_reader_pkg;

  localparam int LANE_W   = 8;
  localparam int SYS_SIZE = 16;
  localparam int SYS_LOG2 = $clog2(SYS_SIZE);

  typedef logic [SYS_SIZE-1:0][LANE_W-1:0] lane_vec_t;

  // Number of bank words needed to hold ram_size bytes (rounded up).
  function automatic int word_count(input int ram_size, input int sys_size);
    return (ram_size + sys_size - 1) / sys_size;
  endfunction

endpackage

// File: rtl/wgt_lane_aligner.sv
// rtl/wgt_lane_aligner.sv - combinational byte re-alignment and lane masking of a two-word window
module wgt_lane_aligner
  import wgt_bank_reader_pkg::*;
#(
  parameter int SYSTOLIC_SIZE = SYS_SIZE,
  parameter int OFF_W         = $clog2(SYSTOLIC_SIZE)
) (
  input  logic [SYSTOLIC_SIZE*LANE_W-1:0] hi,
  input  logic [SYSTOLIC_SIZE*LANE_W-1:0] lo,
  input  logic [OFF_W-1:0]                off,
  input  logic [4:0]                      size,
  input  logic [SYSTOLIC_SIZE-1:0]        rng_mask,
  output logic [SYSTOLIC_SIZE*LANE_W-1:0] data
);

  localparam int VW = SYSTOLIC_SIZE * LANE_W;

  logic [VW-1:0] shifted;

  // Lane 0 of the result is the byte at the request offset inside the low word.
  assign shifted = VW'({hi, lo} >> {off, 3'b000});

  // Zero lanes past the requested size or past the end of weight memory.
  always_comb begin
    data = '0;
    for (int i = 0; i < SYSTOLIC_SIZE; i++) begin
      if (rng_mask[i] && (32'(i) < 32'(size)))
        data[LANE_W*i +: LANE_W] = shifted[LANE_W*i +: LANE_W];
    end
  end

endmodule

// File: rtl/wgt_bank_reader.sv
// rtl/wgt_bank_reader.sv - three-cycle weight reader over even/odd word banks
module wgt_bank_reader
  import wgt_bank_reader_pkg::*;
#(
  parameter int SYSTOLIC_SIZE = SYS_SIZE,
  parameter int WGT_RAM_SIZE  = 8845488,
  parameter int BANK_AW       = $clog2(WGT_RAM_SIZE) - $clog2(SYSTOLIC_SIZE)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              read_en,
  input  logic [$clog2(WGT_RAM_SIZE)-1:0]   wgt_addr,
  input  logic [4:0]                        read_wgt_size,
  output logic                              even_en,
  output logic                              odd_en,
  output logic [BANK_AW-1:0]                even_addr,
  output logic [BANK_AW-1:0]                odd_addr,
  input  logic [SYSTOLIC_SIZE*LANE_W-1:0]   even_rdata,
  input  logic [SYSTOLIC_SIZE*LANE_W-1:0]   odd_rdata,
  output logic [SYSTOLIC_SIZE*LANE_W-1:0]   wgt_data,
  output logic                              wgt_valid,
  output logic [4:0]                        wgt_size,
  output logic                              err
);

  localparam int          AW      = $clog2(WGT_RAM_SIZE);
  localparam int          OW      = $clog2(SYSTOLIC_SIZE);
  localparam int          VW      = SYSTOLIC_SIZE * LANE_W;
  localparam logic [31:0] RAM_END = 32'(WGT_RAM_SIZE);
  localparam logic [31:0] N_WORDS = 32'(word_count(WGT_RAM_SIZE, SYSTOLIC_SIZE));
  localparam logic [4:0]  SZ_MAX  = 5'(SYSTOLIC_SIZE);

  logic [AW-OW-1:0]         w;
  logic [OW-1:0]            off;
  logic [4:0]               size_c;
  logic                     span, lo_ok, hi_ok, err_req;
  logic [SYSTOLIC_SIZE-1:0] rng;

  logic                     s1_valid, s1_wodd;
  logic [OW-1:0]            s1_off;
  logic [4:0]               s1_size;
  logic [SYSTOLIC_SIZE-1:0] s1_rng;

  logic                     s2_valid, s2_wodd;
  logic [OW-1:0]            s2_off;
  logic [4:0]               s2_size;
  logic [SYSTOLIC_SIZE-1:0] s2_rng;

  logic [VW-1:0]            win_hi, win_lo, aligned;

  assign w   = wgt_addr[AW-1:OW];
  assign off = wgt_addr[OW-1:0];

  // Request decode: clamp size, detect word spanning, bank range and per-lane range.
  always_comb begin
    size_c  = (read_wgt_size > SZ_MAX) ? SZ_MAX : read_wgt_size;
    span    = (6'(off) + 6'(size_c)) > 6'(SYSTOLIC_SIZE);
    lo_ok   = 32'(w) < N_WORDS;
    hi_ok   = span && ((32'(w) + 32'd1) < N_WORDS);
    err_req = (32'(wgt_addr) + 32'(size_c)) > RAM_END;
    rng     = '0;
    for (int i = 0; i < SYSTOLIC_SIZE; i++)
      rng[i] = (32'(wgt_addr) + 32'(i)) < RAM_END;
  end

  // S1: bank enables/addresses; word w goes to the bank matching its parity, w+1 to the other.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      even_en   <= 1'b0;
      odd_en    <= 1'b0;
      even_addr <= '0;
      odd_addr  <= '0;
      s1_wodd   <= 1'b0;
      s1_off    <= '0;
      s1_size   <= '0;
      s1_rng    <= '0;
    end else begin
      s1_valid <= read_en;
      even_en  <= read_en && (w[0] ? hi_ok : lo_ok);
      odd_en   <= read_en && (w[0] ? lo_ok : hi_ok);
      if (read_en) begin
        even_addr <= BANK_AW'(w >> 1) + BANK_AW'(w[0]);
        odd_addr  <= BANK_AW'(w >> 1);
        s1_wodd   <= w[0];
        s1_off    <= off;
        s1_size   <= size_c;
        s1_rng    <= rng;
      end
    end
  end

  // Carry S1 metadata one cycle so it lines up with the bank read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_wodd  <= 1'b0;
      s2_off   <= '0;
      s2_size  <= '0;
      s2_rng   <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_wodd  <= s1_wodd;
      s2_off   <= s1_off;
      s2_size  <= s1_size;
      s2_rng   <= s1_rng;
    end
  end

  assign win_lo = s2_wodd ? odd_rdata  : even_rdata;
  assign win_hi = s2_wodd ? even_rdata : odd_rdata;

  wgt_lane_aligner #(
    .SYSTOLIC_SIZE (SYSTOLIC_SIZE),
    .OFF_W         (OW)
  ) u_aligner (
    .hi       (win_hi),
    .lo       (win_lo),
    .off      (s2_off),
    .size     (s2_size),
    .rng_mask (s2_rng),
    .data     (aligned)
  );

  // S2: register the aligned, masked vector and its pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      wgt_valid <= 1'b0;
      wgt_data  <= '0;
      wgt_size  <= '0;
    end else begin
      wgt_valid <= s2_valid;
      if (s2_valid) begin
        wgt_data <= aligned;
        wgt_size <= s2_size;
      end
    end
  end

  // Sticky range error; a new error outranks a simultaneous start.
  always_ff @(posedge clk) begin
    if (rst)
      err <= 1'b0;
    else if (read_en && err_req)
      err <= 1'b1;
    else if (start)
      err <= 1'b0;
  end

endmodule

// File: tb/tb_wgt_bank_reader.sv
// tb/tb_wgt_bank_reader.sv - directed self-checking bench for wgt_bank_reader
module tb_wgt_bank_reader;
  import wgt_bank_reader_pkg::*;

  localparam int RAM = 8845488;

  logic         clk = 1'b0;
  logic         rst, start, read_en;
  logic [23:0]  wgt_addr;
  logic [4:0]   read_wgt_size;
  logic         even_en, odd_en;
  logic [19:0]  even_addr, odd_addr;
  logic [127:0] even_rdata, odd_rdata;
  logic [127:0] wgt_data;
  logic         wgt_valid;
  logic [4:0]   wgt_size;
  logic         err;

  int n_chk  = 0;
  int n_pass = 0;

  wgt_bank_reader dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .read_en       (read_en),
    .wgt_addr      (wgt_addr),
    .read_wgt_size (read_wgt_size),
    .even_en       (even_en),
    .odd_en        (odd_en),
    .even_addr     (even_addr),
    .odd_addr      (odd_addr),
    .even_rdata    (even_rdata),
    .odd_rdata     (odd_rdata),
    .wgt_data      (wgt_data),
    .wgt_valid     (wgt_valid),
    .wgt_size      (wgt_size),
    .err           (err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] byte_at(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h3C;
  endfunction

  function automatic logic [127:0] word_data(input logic [31:0] w);
    logic [127:0] v;
    for (int k = 0; k < 16; k++) v[8*k +: 8] = byte_at(w * 32'd16 + 32'(k));
    return v;
  endfunction

  function automatic logic [127:0] exp_vec(input logic [31:0] a, input int sz);
    lane_vec_t v;
    int n;
    n = (sz > 16) ? 16 : sz;
    v = '0;
    for (int i = 0; i < 16; i++)
      if (i < n && (a + 32'(i)) < 32'(RAM)) v[i] = byte_at(a + 32'(i));
    return v;
  endfunction

  // Bank model: one-cycle read latency, garbage on idle cycles.
  always @(posedge clk) begin
    even_rdata <= even_en ? word_data({11'b0, even_addr, 1'b0}) : {16{8'hA5}};
    odd_rdata  <= odd_en  ? word_data({11'b0, odd_addr, 1'b1})  : {16{8'h5A}};
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic [31:0] a, input int sz, input logic ee, input logic oe,
                        input logic [19:0] ea, input logic [19:0] oa, input logic exp_err);
    read_en = 1'b1; wgt_addr = a[23:0]; read_wgt_size = 5'(sz);
    tick();
    read_en = 1'b0;
    chk("even_en", 128'(even_en), 128'(ee));
    chk("odd_en", 128'(odd_en), 128'(oe));
    if (ee) chk("even_addr", 128'(even_addr), 128'(ea));
    if (oe) chk("odd_addr", 128'(odd_addr), 128'(oa));
    tick();
    chk("valid_early", 128'(wgt_valid), 128'(0));
    tick();
    chk("valid", 128'(wgt_valid), 128'(1));
    chk("data", wgt_data, exp_vec(a, sz));
    chk("size", 128'(wgt_size), 128'((sz > 16) ? 16 : sz));
    chk("err", 128'(err), 128'(exp_err));
    tick();
    chk("valid_late", 128'(wgt_valid), 128'(0));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; read_en = 1'b0; wgt_addr = '0; read_wgt_size = '0;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_even_en", 128'(even_en), 128'(0));
    chk("rst_odd_en", 128'(odd_en), 128'(0));
    chk("rst_even_addr", 128'(even_addr), 128'(0));
    chk("rst_odd_addr", 128'(odd_addr), 128'(0));
    chk("rst_data", wgt_data, 128'(0));
    chk("rst_valid", 128'(wgt_valid), 128'(0));
    chk("rst_size", 128'(wgt_size), 128'(0));
    chk("rst_err", 128'(err), 128'(0));

    do_req(32'h20, 16, 1'b1, 1'b0, 20'd1, 20'd0, 1'b0);            // aligned
    do_req(32'h1A, 16, 1'b1, 1'b1, 20'd1, 20'd0, 1'b0);            // spanning, w odd
    do_req(32'h35, 3, 1'b0, 1'b1, 20'd0, 20'd1, 1'b0);             // partial, odd only
    do_req(32'h40, 0, 1'b1, 1'b0, 20'd2, 20'd0, 1'b0);             // size 0
    do_req(32'h47, 20, 1'b1, 1'b1, 20'd2, 20'd2, 1'b0);            // clamp, spanning, w even
    do_req(32'(RAM - 16), 16, 1'b1, 1'b0, 20'd276421, 20'd0, 1'b0); // exact end, no error
    do_req(32'(RAM - 4), 16, 1'b1, 1'b0, 20'd276421, 20'd0, 1'b1);  // past end

    chk("err_sticky", 128'(err), 128'(1));
    start = 1'b1; tick(); start = 1'b0;
    chk("err_cleared", 128'(err), 128'(0));

    // Error request and start in the same cycle: error wins.
    start = 1'b1; read_en = 1'b1; wgt_addr = 24'(RAM - 4); read_wgt_size = 5'd16;
    tick();
    start = 1'b0; read_en = 1'b0;
    chk("err_set_wins", 128'(err), 128'(1));
    repeat (4) tick();
    start = 1'b1; tick(); start = 1'b0;
    chk("err_cleared2", 128'(err), 128'(0));

    // Back-to-back stream of 64 aligned requests.
    for (int c = 0; c < 67; c++) begin
      if (c < 64) begin
        read_en = 1'b1; wgt_addr = 24'(32'h100 + 32'(16 * c)); read_wgt_size = 5'd16;
      end else begin
        read_en = 1'b0;
      end
      tick();
      if (c >= 2 && c < 66) begin
        chk("stream_valid", 128'(wgt_valid), 128'(1));
        chk("stream_data", wgt_data, exp_vec(32'h100 + 32'(16 * (c - 2)), 16));
      end else begin
        chk("stream_idle", 128'(wgt_valid), 128'(0));
      end
    end

    // Reset with two requests in flight; the request during reset is ignored.
    read_en = 1'b1; wgt_addr = 24'h20; read_wgt_size = 5'd16;
    tick();
    wgt_addr = 24'(RAM - 4);
    tick();
    rst = 1'b1; wgt_addr = 24'(RAM - 4);
    tick();
    rst = 1'b0; read_en = 1'b0;
    chk("mid_even_en", 128'(even_en), 128'(0));
    chk("mid_odd_en", 128'(odd_en), 128'(0));
    chk("mid_even_addr", 128'(even_addr), 128'(0));
    chk("mid_odd_addr", 128'(odd_addr), 128'(0));
    chk("mid_data", wgt_data, 128'(0));
    chk("mid_valid", 128'(wgt_valid), 128'(0));
    chk("mid_size", 128'(wgt_size), 128'(0));
    chk("mid_err", 128'(err), 128'(0));
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("mid_no_valid", 128'(wgt_valid), 128'(0));
      chk("mid_no_en", 128'({even_en, odd_en}), 128'(0));
    end
    chk("mid_err_after", 128'(err), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
